sd_cmd_responder: RTL and testbench
===================================

SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 The block SHALL have parameter NCR, default 2: idle cycles, CMD line high, between the received end bit and the response start bit (range 2..64).
REQ-002 The block SHALL have parameter RESP_TIMEOUT, default 64: cycles after ocmd_valid within which iresp_start is accepted.
REQ-003 iclk  input  1  SD clock; all logic is clocked on the rising edge.
REQ-004 irst  input  1  reset, synchronous, active-high.
REQ-005 icmd_sd  input  1  CMD line as driven by the host.
REQ-006 ocmd_sd  output  1  CMD line value driven by the card.
REQ-007 ocmd_oe  output  1  CMD line output enable.
REQ-008 ocmd_valid  output  1  one-cycle pulse: a valid command was received.
REQ-009 ocmd_index  output  6  index of the last valid command.
REQ-010 ocmd_arg  output  32  argument of the last valid command.
REQ-011 ocrc_err  output  1  one-cycle pulse: CRC error or framing error in a received command.
REQ-012 iresp_start  input  1  request to send a response.
REQ-013 iresp_type  input  2  response format: 00 no response, 01 R1/R6/R7, 10 R2, 11 R3.
REQ-014 iresp_data  input  127  response payload: R1 uses [31:0], R2 uses [126:0], R3 uses [31:0].
REQ-015 obusy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be: IDLE, RCV_CMD, RCV_CRC, RCV_END, WAIT_USER, NCR_GAP, SEND_RESP, SEND_CRC, SEND_END.
REQ-017 IDLE -> RCV_CMD SHALL occur when icmd_sd=0 is sampled; that sample is the start bit.
REQ-018 RCV_CMD SHALL sample 39 bits (transmission bit, 6-bit index, 32-bit argument) MSB first; RCV_CRC SHALL sample 7 CRC bits; RCV_END SHALL sample 1 end bit.
REQ-019 CRC7 SHALL use polynomial x^7+x^3+1 with zero init, computed over the 40 bits from the start bit to the argument LSB.
REQ-020 A frame SHALL be valid only if transmission bit=1, the received CRC equals the computed CRC, and end bit=1.
REQ-021 Valid frame: in the cycle after the end bit, ocmd_valid=1 and ocmd_index/ocmd_arg update in the same cycle; state goes to WAIT_USER.
REQ-022 Invalid frame: in the cycle after the end bit, ocrc_err=1, ocmd_index/ocmd_arg are unchanged, no response is sent, and state returns to IDLE.
REQ-023 WAIT_USER: iresp_start=1 with type!=00 latches iresp_type/iresp_data and goes to NCR_GAP; type=00 goes to IDLE.
REQ-024 WAIT_USER: RESP_TIMEOUT cycles without iresp_start SHALL return the block to IDLE with no response.
REQ-025 iresp_start is ignored in every state except WAIT_USER.
REQ-026 NCR_GAP: the block SHALL hold ocmd_oe=0 until a total of NCR cycles has elapsed since the end-bit cycle.
REQ-027 If NCR has already elapsed when iresp_start arrives, SEND_RESP SHALL begin on the next cycle.
REQ-028 SEND_RESP frame, R1: 0, 0, ocmd_index[5:0], data[31:0], then 7 CRC bits over those 40 bits, then end bit 1; 48 bits total.
REQ-029 SEND_RESP frame, R2: 0, 0, 111111, data[126:0] raw with no CRC generated, then end bit 1; 136 bits total.
REQ-030 SEND_RESP frame, R3: 0, 0, 111111, data[31:0], then 1111111 (not a CRC), then end bit 1; 48 bits total.
REQ-031 ocmd_oe SHALL be 1 from the start bit through the end bit inclusive and 0 otherwise; ocmd_sd SHALL be 1 whenever ocmd_oe=0.
REQ-032 After SEND_END the block SHALL return to IDLE, and start-bit detection is enabled on the following cycle.
REQ-033 icmd_sd SHALL be ignored while ocmd_oe=1 (no collision detection).
REQ-034 Bit counters SHALL be 8 bits and count down to zero per state; state changes when the count reaches 0.

Reset
REQ-035 On irst=1 the block SHALL go to IDLE with ocmd_sd=1, ocmd_oe=0, ocmd_valid=0, ocrc_err=0, ocmd_index=0, ocmd_arg=0, obusy=0, and counters and CRC cleared.
REQ-036 Reset SHALL take effect in any state, including mid-response; ocmd_oe=0 SHALL hold from the cycle after irst is sampled.

Verification
REQ-037 Host sends 0x40_00000000_95 (CMD0) -> ocmd_valid for 1 cycle, index=0, arg=0; iresp_type=00 -> no line activity and obusy drops.
REQ-038 Host sends 0x48_000001AA_87 (CMD8); user sets iresp_start with type=01 and data=0x000001AA immediately -> line high for 2 cycles, then 48-bit frame 0x08_000001AA_xx whose CRC matches the model and whose end bit is 1.
REQ-039 CMD17 sent as 0x51_00000000_55 but with the CRC byte corrupted to 0x57 -> ocrc_err pulse, no ocmd_valid, and ocmd_oe stays 0.
REQ-040 CMD2 valid, then type=10 with a known 127-bit CID -> 136 bits on the line, bit 0 = 1, and ocmd_oe high for exactly 136 cycles.
REQ-041 Valid command with no iresp_start for 64 cycles -> IDLE, no response; a later iresp_start is ignored.
REQ-042 irst asserted at bit 20 of an R1 response -> ocmd_oe=0 on the next cycle; a following CMD0 is received correctly.

Source files
------------

// File: rtl/sd_cmd_responder.sv
// SD card command-line responder: receives 48-bit host commands, checks CRC7,
// and sends an R1/R2/R3 response after the NCR gap when the user requests one.
module sd_cmd_responder #(
    parameter int NCR          = 2,
    parameter int RESP_TIMEOUT = 64
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         icmd_sd,
    output logic         ocmd_sd,
    output logic         ocmd_oe,
    output logic         ocmd_valid,
    output logic [5:0]   ocmd_index,
    output logic [31:0]  ocmd_arg,
    output logic         ocrc_err,
    input  logic         iresp_start,
    input  logic [1:0]   iresp_type,
    input  logic [126:0] iresp_data,
    output logic         obusy
);
    localparam int TOW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_R2   = 2'b10;
    localparam logic [1:0] RESP_R3   = 2'b11;

    typedef enum logic [3:0] {
        IDLE, RCV_CMD, RCV_CRC, RCV_END, WAIT_USER,
        NCR_GAP, SEND_RESP, SEND_CRC, SEND_END
    } state_t;

    state_t          state_reg, state_next;
    logic [7:0]      bit_cnt_reg;
    logic [7:0]      gap_cnt_reg;
    logic [TOW-1:0]  to_cnt_reg;
    logic [38:0]     rx_sr_reg;
    logic [6:0]      crc_reg;
    logic [6:0]      crc_rx_reg;
    logic [134:0]    tx_sr_reg;
    logic [1:0]      resp_type_reg;
    logic            cmd_valid_reg;
    logic            crc_err_reg;
    logic [5:0]      cmd_index_reg;
    logic [31:0]     cmd_arg_reg;
    logic            frame_ok;
    logic            gap_done;
    logic            to_done;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
    endfunction

    // Start bit is always 0, so a zero-init CRC is unchanged by it.
    assign frame_ok = rx_sr_reg[38] && (crc_rx_reg == crc_reg) && icmd_sd;
    assign gap_done = (gap_cnt_reg == 8'd0);
    assign to_done  = (to_cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:      if (!icmd_sd) state_next = RCV_CMD;
            RCV_CMD:   if (bit_cnt_reg == 8'd0) state_next = RCV_CRC;
            RCV_CRC:   if (bit_cnt_reg == 8'd0) state_next = RCV_END;
            RCV_END:   state_next = frame_ok ? WAIT_USER : IDLE;
            WAIT_USER: begin
                if (iresp_start) begin
                    if (iresp_type == RESP_NONE) state_next = IDLE;
                    else if (gap_done)           state_next = SEND_RESP;
                    else                         state_next = NCR_GAP;
                end else if (to_done) begin
                    state_next = IDLE;
                end
            end
            NCR_GAP:   if (gap_done) state_next = SEND_RESP;
            SEND_RESP: if (bit_cnt_reg == 8'd0)
                           state_next = (resp_type_reg == RESP_R2) ? SEND_END : SEND_CRC;
            SEND_CRC:  if (bit_cnt_reg == 8'd0) state_next = SEND_END;
            SEND_END:  state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            to_cnt_reg    <= '0;
            rx_sr_reg     <= '0;
            crc_reg       <= '0;
            crc_rx_reg    <= '0;
            tx_sr_reg     <= '0;
            resp_type_reg <= '0;
            cmd_valid_reg <= 1'b0;
            crc_err_reg   <= 1'b0;
            cmd_index_reg <= '0;
            cmd_arg_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_valid_reg <= 1'b0;
            crc_err_reg   <= 1'b0;
            if (!gap_done) gap_cnt_reg <= gap_cnt_reg - 8'd1;
            unique case (state_reg)
                IDLE: if (!icmd_sd) begin
                    bit_cnt_reg <= 8'd38;
                    crc_reg     <= '0;
                end
                RCV_CMD: begin
                    rx_sr_reg   <= {rx_sr_reg[37:0], icmd_sd};
                    crc_reg     <= crc7_step(crc_reg, icmd_sd);
                    bit_cnt_reg <= (bit_cnt_reg == 8'd0) ? 8'd6 : bit_cnt_reg - 8'd1;
                end
                RCV_CRC: begin
                    crc_rx_reg <= {crc_rx_reg[5:0], icmd_sd};
                    if (bit_cnt_reg != 8'd0) bit_cnt_reg <= bit_cnt_reg - 8'd1;
                end
                RCV_END: begin
                    if (frame_ok) begin
                        cmd_valid_reg <= 1'b1;
                        cmd_index_reg <= rx_sr_reg[37:32];
                        cmd_arg_reg   <= rx_sr_reg[31:0];
                    end else begin
                        crc_err_reg <= 1'b1;
                    end
                    // Gap is measured from the end-bit cycle, so count the next cycle as 1.
                    gap_cnt_reg <= 8'(NCR - 1);
                    to_cnt_reg  <= TOW'(RESP_TIMEOUT - 1);
                end
                WAIT_USER: begin
                    if (iresp_start && iresp_type != RESP_NONE) begin
                        resp_type_reg <= iresp_type;
                        crc_reg       <= '0;
                        bit_cnt_reg   <= (iresp_type == RESP_R2) ? 8'd134 : 8'd39;
                        if (iresp_type == RESP_R2)
                            tx_sr_reg <= {2'b00, 6'h3F, iresp_data};
                        else if (iresp_type == RESP_R3)
                            tx_sr_reg <= {2'b00, 6'h3F, iresp_data[31:0], 95'd0};
                        else
                            tx_sr_reg <= {2'b00, cmd_index_reg, iresp_data[31:0], 95'd0};
                    end else if (!to_done) begin
                        to_cnt_reg <= to_cnt_reg - 1'b1;
                    end
                end
                SEND_RESP: begin
                    crc_reg     <= crc7_step(crc_reg, tx_sr_reg[134]);
                    tx_sr_reg   <= {tx_sr_reg[133:0], 1'b0};
                    bit_cnt_reg <= (bit_cnt_reg == 8'd0) ? 8'd6 : bit_cnt_reg - 8'd1;
                end
                SEND_CRC: begin
                    crc_reg <= {crc_reg[5:0], 1'b0};
                    if (bit_cnt_reg != 8'd0) bit_cnt_reg <= bit_cnt_reg - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ocmd_oe = 1'b0;
        ocmd_sd = 1'b1;
        unique case (state_reg)
            SEND_RESP: begin ocmd_oe = 1'b1; ocmd_sd = tx_sr_reg[134]; end
            SEND_CRC:  begin
                ocmd_oe = 1'b1;
                ocmd_sd = (resp_type_reg == RESP_R3) ? 1'b1 : crc_reg[6];
            end
            SEND_END:  ocmd_oe = 1'b1;
            default: ;
        endcase
    end

    assign ocmd_valid = cmd_valid_reg;
    assign ocrc_err   = crc_err_reg;
    assign ocmd_index = cmd_index_reg;
    assign ocmd_arg   = cmd_arg_reg;
    assign obusy      = (state_reg != IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Randomized and directed bench for sd_cmd_responder against a frame-level
// reference model (polynomial-division CRC7, expected response bit vectors).
module tb_sd_cmd_responder;
    localparam int NCR          = 2;
    localparam int RESP_TIMEOUT = 64;
    localparam int WIN          = 200;

    logic         iclk = 1'b0;
    logic         irst, icmd_sd, iresp_start;
    logic [1:0]   iresp_type;
    logic [126:0] iresp_data;
    logic         ocmd_sd, ocmd_oe, ocmd_valid, ocrc_err, obusy;
    logic [5:0]   ocmd_index;
    logic [31:0]  ocmd_arg;

    always #5 iclk = ~iclk;

    sd_cmd_responder #(.NCR(NCR), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
        .iclk(iclk), .irst(irst), .icmd_sd(icmd_sd),
        .ocmd_sd(ocmd_sd), .ocmd_oe(ocmd_oe), .ocmd_valid(ocmd_valid),
        .ocmd_index(ocmd_index), .ocmd_arg(ocmd_arg), .ocrc_err(ocrc_err),
        .iresp_start(iresp_start), .iresp_type(iresp_type),
        .iresp_data(iresp_data), .obusy(obusy)
    );

    int checks = 0;
    int errors = 0;
    logic log_oe[WIN], log_sd[WIN], log_busy[WIN], log_valid[WIN];
    logic [5:0]  last_idx;
    logic [31:0] last_arg;

    task automatic check_val(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %0s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_div(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic logic [47:0] make_cmd(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, crc7_div({2'b01, idx, arg}), 1'b1};
    endfunction

    task automatic resp_frame(input logic [1:0] t, input logic [5:0] idx, input logic [126:0] d,
                              output logic [135:0] f, output int n);
        logic [39:0] h;
        f = '0;
        n = 0;
        case (t)
            2'b01: begin h = {2'b00, idx, d[31:0]}; f = {h, crc7_div(h), 1'b1, 88'd0}; n = 48; end
            2'b10: begin f = {2'b00, 6'h3F, d, 1'b1}; n = 136; end
            2'b11: begin f = {2'b00, 6'h3F, d[31:0], 7'h7F, 1'b1, 88'd0}; n = 48; end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic send_cmd(input logic [47:0] c);
        for (int i = 47; i >= 0; i--) begin
            icmd_sd = c[i];
            tick();
        end
        icmd_sd = 1'b1;
    endtask

    // k=0 is the cycle right after the end bit; iresp_start is high only in cycle k=d.
    task automatic run_resp(input int d, input logic [1:0] t, input logic [126:0] data);
        iresp_type = t;
        iresp_data = data;
        for (int k = 0; k < WIN; k++) begin
            log_oe[k] = ocmd_oe; log_sd[k] = ocmd_sd;
            log_busy[k] = obusy; log_valid[k] = ocmd_valid;
            iresp_start = (k == d);
            tick();
        end
        iresp_start = 1'b0;
    endtask

    task automatic analyze(input logic exp_send, input int exp_first, input int n,
                           input logic [135:0] exp_frame);
        int first_k, ones, bad_idle;
        logic [135:0] obs;
        first_k = -1; ones = 0; bad_idle = 0; obs = '0;
        for (int k = 0; k < WIN; k++) begin
            if (log_oe[k]) begin
                if (first_k < 0) first_k = k;
                ones++;
            end else if (!log_sd[k]) begin
                bad_idle++;
            end
        end
        if (exp_send) begin
            check_val("resp_start_cycle", 136'(first_k), 136'(exp_first));
            check_val("oe_cycles", 136'(ones), 136'(n));
            if (first_k >= 0)
                for (int j = 0; j < n; j++)
                    if (first_k + j < WIN) obs[135 - j] = log_sd[first_k + j];
            check_val("resp_frame", obs, exp_frame);
        end else begin
            check_val("no_resp_oe", 136'(ones), 136'd0);
        end
        check_val("sd_high_when_idle", 136'(bad_idle), 136'd0);
        check_val("valid_one_cycle", 136'(log_valid[1]), 136'd0);
        check_val("idle_at_end", 136'(log_busy[WIN-1]), 136'd0);
    endtask

    task automatic do_txn(input string name, input logic [47:0] fr, input int d,
                          input logic [1:0] t, input logic [126:0] data);
        logic v, es;
        logic [135:0] ef;
        int n, ex_first;
        v = fr[46] && fr[0] && (fr[7:1] == crc7_div(fr[47:8]));
        send_cmd(fr);
        check_val("cmd_valid", 136'(ocmd_valid), 136'(v));
        check_val("crc_err", 136'(ocrc_err), 136'(!v));
        if (v) begin
            last_idx = fr[45:40];
            last_arg = fr[39:8];
        end
        check_val("cmd_index", 136'(ocmd_index), 136'(last_idx));
        check_val("cmd_arg", 136'(ocmd_arg), 136'(last_arg));
        es = v && (t != 2'b00) && (d >= 0) && (d < RESP_TIMEOUT);
        ex_first = (d + 1 > NCR) ? d + 1 : NCR;
        resp_frame(t, last_idx, data, ef, n);
        run_resp(d, t, data);
        analyze(es, ex_first, n, ef);
        if (v && t == 2'b00 && d >= 0) begin
            check_val("busy_before_none", 136'(log_busy[d]), 136'd1);
            check_val("busy_after_none", 136'(log_busy[d + 1]), 136'd0);
        end
        if (v && d < 0) begin
            check_val("busy_last_wait", 136'(log_busy[RESP_TIMEOUT - 1]), 136'd1);
            check_val("busy_timeout", 136'(log_busy[RESP_TIMEOUT]), 136'd0);
        end
        $display("txn %0s: cmd=%012h valid=%0b type=%0d delay=%0d resp=%0b",
                 name, fr, v, t, d, es);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [47:0]  c;
        logic [126:0] data;
        logic [1:0]   t;
        int           d, ones;

        irst = 1'b1; icmd_sd = 1'b1; iresp_start = 1'b0;
        iresp_type = '0; iresp_data = '0;
        last_idx = '0; last_arg = '0;
        repeat (3) tick();
        check_val("rst_oe", 136'(ocmd_oe), 136'd0);
        check_val("rst_sd", 136'(ocmd_sd), 136'd1);
        check_val("rst_busy", 136'(obusy), 136'd0);
        check_val("rst_valid", 136'(ocmd_valid), 136'd0);
        check_val("rst_err", 136'(ocrc_err), 136'd0);
        check_val("rst_index", 136'(ocmd_index), 136'd0);
        check_val("rst_arg", 136'(ocmd_arg), 136'd0);
        irst = 1'b0;
        repeat (2) tick();

        do_txn("CMD0", 48'h40_00000000_95, 0, 2'b00, '0);
        do_txn("CMD8_R1", 48'h48_000001AA_87, 0, 2'b01, 127'h1AA);
        do_txn("CMD17_badcrc", 48'h51_00000000_57, 0, 2'b01, 127'h5);
        do_txn("CMD2_R2", make_cmd(6'd2, 32'h0), 0, 2'b10,
               127'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321);
        do_txn("CMD9_timeout", make_cmd(6'd9, 32'h1234_0000), -1, 2'b01, 127'h77);
        run_resp(3, 2'b01, 127'h77);
        analyze(1'b0, 0, 0, '0);
        $display("txn late_start: delay=3 resp=0");

        // Reset in the middle of an R1 response.
        send_cmd(48'h48_000001AA_87);
        iresp_type = 2'b01; iresp_data = 127'h1AA; iresp_start = 1'b1;
        tick();
        iresp_start = 1'b0;
        ones = 0;
        for (int k = 0; k < 100; k++) begin
            if (ocmd_oe) ones++;
            if (ones == 20) break;
            tick();
        end
        check_val("rst_mid_reach", 136'(ones), 136'd20);
        irst = 1'b1;
        tick();
        check_val("rst_mid_oe", 136'(ocmd_oe), 136'd0);
        check_val("rst_mid_sd", 136'(ocmd_sd), 136'd1);
        irst = 1'b0;
        last_idx = '0; last_arg = '0;
        tick();
        $display("txn reset_mid_resp: oe_bits_before_reset=%0d", ones);
        do_txn("CMD0_after_reset", 48'h40_00000000_95, 0, 2'b00, '0);

        for (int i = 0; i < 24; i++) begin
            c = make_cmd(6'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom_range(0, 46);
                c[d] = ~c[d];
            end
            t = 2'($urandom);
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            data = 127'({$urandom, $urandom, $urandom, $urandom});
            do_txn($sformatf("rand%0d", i), c, d, t, data);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
